// File: rtl/pri_irq_pkg.sv
// ------------------------------------------------------------------
// pri_irq_pkg : shared constants and state type for pri_irq_ctrl
// Revision    : 1.0
// ------------------------------------------------------------------
`default_nettype none

package pri_irq_pkg;
  localparam int NCH = 8;
  localparam int VW  = 3;
  localparam logic [NCH-1:0] I_INACTIVE = 8'hFF;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;
endpackage

`default_nettype wire

// File: rtl/pri_enc8.sv
// ------------------------------------------------------------------
// pri_enc8 : combinational 8-to-3 priority encoder, highest index wins
// Revision : 1.0
// ------------------------------------------------------------------
`default_nettype none

module pri_enc8
  import pri_irq_pkg::*;
(
  input  logic [NCH-1:0] req,
  output logic [VW-1:0]  idx,
  output logic           valid
);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (req[k]) begin
        idx   = VW'(k);
        valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pri_irq_ctrl.sv
// ------------------------------------------------------------------
// pri_irq_ctrl : 8-channel edge-captured, maskable priority interrupt controller
// Revision     : 1.0
// ------------------------------------------------------------------
`default_nettype none

module pri_irq_ctrl
  import pri_irq_pkg::*;
#(
  parameter logic [NCH-1:0] MASK_RST = 8'h00
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] I_n,
  input  logic           EI_n,
  input  logic           mask_we,
  input  logic [NCH-1:0] mask_din,
  input  logic           ack,
  output logic           irq,
  output logic [VW-1:0]  vec,
  output logic [NCH-1:0] pend,
  output logic           busy_n
);

  logic [NCH-1:0] i_q;
  logic [NCH-1:0] mask;
  logic           armed;
  state_t         state;
  state_t         state_d;
  logic [VW-1:0]  vec_d;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] clr;
  logic [NCH-1:0] pend_d;
  logic [NCH-1:0] mask_d;
  logic [NCH-1:0] req;
  logic [VW-1:0]  enc_idx;
  logic           enc_valid;

  // A level already low when reset releases is not an edge.
  assign rise   = armed ? (i_q & ~I_n) : '0;
  assign pend_d = (pend & ~clr) | rise;
  assign mask_d = mask_we ? mask_din : mask;
  assign req    = pend & ~mask;

  always_comb begin
    clr = '0;
    if (state == S_GRANT && ack) clr[vec] = 1'b1;
  end

  pri_enc8 u_enc (
    .req   (req),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_comb begin
    state_d = state;
    vec_d   = vec;
    case (state)
      S_IDLE: begin
        if (!EI_n && enc_valid) begin
          state_d = S_GRANT;
          vec_d   = enc_idx;
        end
      end
      S_GRANT: begin
        if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      i_q    <= I_INACTIVE;
      armed  <= 1'b0;
      pend   <= '0;
      mask   <= MASK_RST;
      irq    <= 1'b0;
      vec    <= '0;
      busy_n <= 1'b1;
    end else begin
      state  <= state_d;
      i_q    <= I_n;
      armed  <= 1'b1;
      pend   <= pend_d;
      mask   <= mask_d;
      irq    <= (state_d == S_GRANT);
      vec    <= vec_d;
      busy_n <= ~(|(pend_d & ~mask_d));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pri_irq_ctrl.sv
// ------------------------------------------------------------------
// tb_pri_irq_ctrl : table, directed and random checks of pri_irq_ctrl
// Revision        : 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_pri_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] I_n = 8'hFF;
  logic       EI_n = 1'b0;
  logic       mask_we = 1'b0;
  logic [7:0] mask_din = 8'h00;
  logic       ack = 1'b0;
  logic       irq;
  logic [2:0] vec;
  logic [7:0] pend;
  logic       busy_n;

  int n_chk = 0;
  int n_err = 0;

  pri_irq_ctrl #(.MASK_RST(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .I_n(I_n), .EI_n(EI_n), .mask_we(mask_we),
    .mask_din(mask_din), .ack(ack), .irq(irq), .vec(vec), .pend(pend), .busy_n(busy_n)
  );

  always #5 clk = ~clk;

  // Reference model: per-channel pending flags, a "grant outstanding" flag
  bit m_iq[8], m_pend[8], m_mask[8];
  bit m_irq, m_armed, m_busy_n = 1'b1;
  int m_vec;

  task automatic model_step(input logic r, input logic [7:0] i, input logic e,
                            input logic mw, input logic [7:0] md, input logic a);
    bit np[8];
    int hi;
    if (!r) begin
      for (int k = 0; k < 8; k++) begin
        m_iq[k] = 1'b1; m_pend[k] = 1'b0; m_mask[k] = 1'b0;
      end
      m_irq = 0; m_vec = 0; m_busy_n = 1; m_armed = 0;
      return;
    end
    hi = -1;
    for (int k = 0; k < 8; k++) if (m_pend[k] && !m_mask[k]) hi = k;
    for (int k = 0; k < 8; k++) begin
      np[k] = m_pend[k];
      if (m_irq && a && k == m_vec) np[k] = 1'b0;
      if (m_armed && m_iq[k] && !i[k]) np[k] = 1'b1;
    end
    if (m_irq) begin
      if (a) m_irq = 1'b0;
    end else if (!e && hi >= 0) begin
      m_irq = 1'b1;
      m_vec = hi;
    end
    m_busy_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      m_pend[k] = np[k];
      if (mw) m_mask[k] = md[k];
      m_iq[k] = i[k];
      if (m_pend[k] && !m_mask[k]) m_busy_n = 1'b0;
    end
    m_armed = 1'b1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input logic r, input logic [7:0] i, input logic e,
                      input logic mw, input logic [7:0] md, input logic a);
    logic [7:0] mp;
    rst_n = r; I_n = i; EI_n = e; mask_we = mw; mask_din = md; ack = a;
    @(posedge clk);
    #1;
    model_step(r, i, e, mw, md, a);
    for (int k = 0; k < 8; k++) mp[k] = m_pend[k];
    chk("model_irq", int'(irq), int'(m_irq));
    chk("model_pend", int'(pend), int'(mp));
    chk("model_busy_n", int'(busy_n), int'(m_busy_n));
    if (m_irq) chk("model_vec", int'(vec), m_vec);
  endtask

  // Simple wrapper: normal operation, EI_n low, no mask write
  task automatic step(input logic [7:0] i, input logic a);
    tick(1'b1, i, 1'b0, 1'b0, 8'h00, a);
  endtask

  typedef struct {
    logic       rst_n;
    logic [7:0] i_n;
    logic       ei_n;
    logic       mwe;
    logic [7:0] mdin;
    logic       ack;
    logic       e_irq;
    logic [2:0] e_vec;
    logic [7:0] e_pend;
    logic       e_busy_n;
  } vec_t;

  vec_t tbl[14];
  logic [7:0] i_cur;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1};
    tbl[1]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1};
    tbl[2]  = '{1'b1, 8'h38, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'hC7, 1'b0};
    tbl[3]  = '{1'b1, 8'h38, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd7, 8'hC7, 1'b0};
    tbl[4]  = '{1'b1, 8'h38, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd7, 8'h47, 1'b0};
    tbl[5]  = '{1'b1, 8'h38, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd6, 8'h47, 1'b0};
    tbl[6]  = '{1'b1, 8'h38, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd6, 8'h07, 1'b0};
    tbl[7]  = '{1'b1, 8'h38, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 8'h07, 1'b0};
    tbl[8]  = '{1'b1, 8'h38, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 8'h03, 1'b0};
    tbl[9]  = '{1'b1, 8'h38, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 8'h03, 1'b0};
    tbl[10] = '{1'b1, 8'h38, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 3'd2, 8'h03, 1'b1};
    tbl[11] = '{1'b1, 8'h38, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 8'h03, 1'b1};
    tbl[12] = '{1'b1, 8'h38, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd2, 8'h03, 1'b0};
    tbl[13] = '{1'b1, 8'h38, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 8'h03, 1'b0};

    for (int t = 0; t < 14; t++) begin
      tick(tbl[t].rst_n, tbl[t].i_n, tbl[t].ei_n, tbl[t].mwe, tbl[t].mdin, tbl[t].ack);
      chk($sformatf("tbl%0d_irq", t), int'(irq), int'(tbl[t].e_irq));
      chk($sformatf("tbl%0d_vec", t), int'(vec), int'(tbl[t].e_vec));
      chk($sformatf("tbl%0d_pend", t), int'(pend), int'(tbl[t].e_pend));
      chk($sformatf("tbl%0d_busy_n", t), int'(busy_n), int'(tbl[t].e_busy_n));
    end

    // EI_n blocks grants while capture continues
    tick(1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'hF7, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("ei_pend", int'(pend), 8'h08);
    chk("ei_busy_n", int'(busy_n), 0);
    tick(1'b1, 8'hF7, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("ei_blocked_irq", int'(irq), 0);
    tick(1'b1, 8'hF7, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("ei_grant_irq", int'(irq), 1);
    chk("ei_grant_vec", int'(vec), 3);

    // Masked channel 7 waits behind channel 5 until unmasked
    tick(1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0);
    step(8'h5F, 1'b0);
    step(8'h5F, 1'b0);
    chk("mask_first_vec", int'(vec), 5);
    step(8'h5F, 1'b1);
    step(8'h5F, 1'b0);
    step(8'h5F, 1'b0);
    chk("mask_hold_irq", int'(irq), 0);
    chk("mask_hold_pend", int'(pend), 8'h80);
    tick(1'b1, 8'h5F, 1'b0, 1'b1, 8'h00, 1'b0);
    step(8'h5F, 1'b0);
    chk("mask_clr_irq", int'(irq), 1);
    chk("mask_clr_vec", int'(vec), 7);

    // Higher-priority arrival does not preempt an active grant
    tick(1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0);
    step(8'hFF, 1'b0);
    step(8'hFD, 1'b0);
    step(8'hFD, 1'b0);
    step(8'hBD, 1'b0);
    step(8'hBD, 1'b0);
    chk("pre_hold_vec", int'(vec), 1);
    chk("pre_pend", int'(pend), 8'h42);
    step(8'hBD, 1'b1);
    step(8'hBD, 1'b0);
    chk("pre_next_vec", int'(vec), 6);

    // Ack collides with a fresh edge on the granted channel
    tick(1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0);
    step(8'hFF, 1'b0);
    step(8'hEF, 1'b0);
    step(8'hEF, 1'b0);
    chk("coll_vec", int'(vec), 4);
    step(8'hFF, 1'b0);
    step(8'hEF, 1'b1);
    chk("coll_pend", int'(pend), 8'h10);
    chk("coll_irq", int'(irq), 0);
    step(8'hEF, 1'b0);
    chk("coll_regrant_irq", int'(irq), 1);
    chk("coll_regrant_vec", int'(vec), 4);

    // Reset mid-grant with all lines held low
    tick(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_irq", int'(irq), 0);
    chk("rst_vec", int'(vec), 0);
    chk("rst_pend", int'(pend), 0);
    chk("rst_busy_n", int'(busy_n), 1);
    for (int t = 0; t < 3; t++) begin
      step(8'h00, 1'b0);
      chk("rst_held_pend", int'(pend), 0);
    end
    step(8'hFF, 1'b0);
    step(8'h00, 1'b0);
    chk("rst_rearm_pend", int'(pend), 8'hFF);

    // Randomized traffic against the reference model
    tick(1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0);
    i_cur = 8'hFF;
    for (int t = 0; t < 800; t++) begin
      i_cur = i_cur ^ 8'($urandom & $urandom);
      tick(logic'($urandom_range(0, 99) != 0), i_cur,
           logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 15) == 0),
           8'($urandom & $urandom), logic'($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
